cache_miss_sequencer: RTL and testbench
=======================================

Name: cache_miss_sequencer

Overview:
- Per-request controller that sits between the cache controller's lookup stage and the eviction-policy block (LRU/FIFO/etc.).
- On each lookup it forwards the hit update to the policy, or runs miss handling: victim select → optional writeback → fill → allocate update.
- Owns the policy handshake (hit, evict request/ready, allocate) so the policy never sees overlapping requests.
- Processes one request at a time (blocking).

Parameters:
- NUM_WAYS, 8, associativity; all way vectors are one-hot of this width (must be ≥2).
- ADDRESS_WIDTH, 32, request/fill address width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  lookup result valid.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_addr  in  ADDRESS_WIDTH  line address of the lookup.
- req_hit  in  1  lookup hit.
- req_hit_way  in  NUM_WAYS  one-hot hit way; ignored on miss.
- way_valid  in  NUM_WAYS  per-way valid bits of the indexed set; sampled at accept.
- way_dirty  in  NUM_WAYS  per-way dirty bits of the indexed set; sampled at accept.
- pol_hit  out  1  one-cycle hit-update strobe to the policy.
- pol_hit_way  out  NUM_WAYS  way for pol_hit.
- pol_evict_req  out  1  request for an eviction target.
- pol_evict_ready  in  1  policy target valid.
- pol_evict_target  in  NUM_WAYS  one-hot victim from the policy.
- pol_allocate  out  1  one-cycle allocate strobe to the policy.
- pol_allocate_way  out  NUM_WAYS  way for pol_allocate.
- wb_req  out  1  writeback of the victim line requested.
- wb_way  out  NUM_WAYS  victim way to write back.
- wb_done  in  1  writeback complete.
- fill_req  out  1  line fill requested.
- fill_addr  out  ADDRESS_WIDTH  address to fill (latched req_addr).
- fill_way  out  NUM_WAYS  destination way.
- fill_done  in  1  fill complete.
- done  out  1  one-cycle completion strobe.
- done_way  out  NUM_WAYS  way hit or allocated; valid with done.
- victim_err  out  1  one-cycle pulse when pol_evict_target is not one-hot.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs 0 except req_ready=1; latched addr/way/dirty cleared.
  - Reset mid-operation abandons the request; no done is produced.
- Accept occurs on req_valid && req_ready (IDLE only). At accept, latch req_addr, req_hit_way, way_valid, way_dirty.
- States: IDLE, HIT_UPD, VICTIM, WRITEBACK, FILL, ALLOC.
- IDLE:
  - accept with req_hit=1 → HIT_UPD.
  - accept with req_hit=0 → VICTIM.
- HIT_UPD (1 cycle): pol_hit=1, pol_hit_way=latched way, done=1, done_way=same → IDLE.
  - Hit latency: done asserts in the cycle after accept.
- VICTIM:
  - If any latched valid bit is 0: victim = lowest-index invalid way; pol_evict_req stays 0 → FILL next cycle.
  - Otherwise pol_evict_req=1 is held until pol_evict_ready=1. In that cycle latch victim=pol_evict_target and drop pol_evict_req in the following cycle.
  - Non-one-hot target: victim_err pulses and victim = lowest set bit, or way 0 if the target is all-zero.
  - Next state: latched dirty[victim]=1 → WRITEBACK, else → FILL.
  - A pol_evict_ready arriving while pol_evict_req=0 is ignored.
- WRITEBACK: wb_req=1, wb_way=victim, held until wb_done=1 → FILL. wb_done in the same cycle as entry is valid.
- FILL: fill_req=1, fill_addr/fill_way latched, held until fill_done=1 → ALLOC.
- ALLOC (1 cycle): pol_allocate=1, pol_allocate_way=victim, done=1, done_way=victim → IDLE.
- Strobes and exclusivity:
  - pol_hit, pol_allocate and done are single-cycle.
  - pol_hit and pol_allocate are mutually exclusive.
  - At most one of wb_req/fill_req/pol_evict_req is high in any cycle.
- Minimum miss latency (invalid way, fill_done immediate): accept→VICTIM→FILL→ALLOC, so done 3 cycles after accept.
- Next req_ready=1 is the cycle after done.
- wb_done/fill_done outside their states are ignored.
- All way outputs are 0 when their strobe is low.

Decomposition:
- Package cache_seq_pkg holds:
  - seq_state_e enum (IDLE..ALLOC, 3-bit encoding).
  - function is_onehot(vec).
  - function lowest_set(vec) → one-hot.
- Sub-module way_prio_enc: parameterised NUM_WAYS lowest-index one-hot priority encoder with an any_set output.
  - Instantiated twice: invalid-way select and non-one-hot target fallback.

Test Plan:
- Hit: NUM_WAYS=8, accept req_hit=1, req_hit_way=8'b0000_0100 → next cycle pol_hit=1, pol_hit_way=8'h04, done=1, done_way=8'h04; req_ready=1 the cycle after.
- Miss with invalid way: way_valid=8'b1111_0111, fill_done tied 1 → pol_evict_req never asserts; fill_way=8'h08; pol_allocate with 8'h08 and done 3 cycles after accept.
- Miss, clean victim: way_valid=8'hFF, way_dirty=8'h00, pol_evict_ready after 4 cycles with target 8'h20 → pol_evict_req held 4 cycles; no wb_req; fill_way=8'h20; pol_allocate_way=8'h20.
- Miss, dirty victim: way_dirty=8'h20, target 8'h20, wb_done after 5 cycles → wb_req held 5 cycles with wb_way=8'h20; fill_req only after wb_done; fill_addr=req_addr=32'hDEAD_BEC0.
- Bad target: target 8'b0011_0000 → victim_err 1-cycle pulse; victim=8'h10. Target 8'h00 → victim_err; victim=8'h01.
- Reset mid-fill: drop reset_n while fill_req=1 → fill_req, done and pol_allocate go 0 immediately; req_ready=1; a new hit request then completes normally.

Source files
------------

// File: rtl/cache_miss_sequencer_pkg.sv
// rtl/cache_miss_sequencer_pkg.sv - shared state encoding and way-vector helpers for the miss sequencer
package cache_seq_pkg;

   // Widest way vector the helpers accept; callers zero-extend narrower vectors.
   localparam int MAX_WAYS = 64;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      HIT_UPD   = 3'd1,
      VICTIM    = 3'd2,
      WRITEBACK = 3'd3,
      FILL      = 3'd4,
      ALLOC     = 3'd5
   } seq_state_e;

   // True when exactly one bit is set.
   function automatic logic is_onehot(input logic [MAX_WAYS-1:0] vec);
      return (vec != '0) && ((vec & (vec - MAX_WAYS'(1))) == '0);
   endfunction

   // Isolates the lowest set bit as a one-hot vector (zero in, zero out).
   function automatic logic [MAX_WAYS-1:0] lowest_set(input logic [MAX_WAYS-1:0] vec);
      return vec & (~vec + MAX_WAYS'(1));
   endfunction

endpackage

// File: rtl/cache_miss_sequencer_if.sv
// rtl/cache_miss_sequencer_if.sv - lookup, policy, writeback and fill handshakes of the miss sequencer
interface cache_miss_sequencer_if #(
   parameter int NUM_WAYS      = 8,
   parameter int ADDRESS_WIDTH = 32
);
   logic                     req_valid;
   logic                     req_ready;
   logic [ADDRESS_WIDTH-1:0] req_addr;
   logic                     req_hit;
   logic [NUM_WAYS-1:0]      req_hit_way;
   logic [NUM_WAYS-1:0]      way_valid;
   logic [NUM_WAYS-1:0]      way_dirty;
   logic                     pol_hit;
   logic [NUM_WAYS-1:0]      pol_hit_way;
   logic                     pol_evict_req;
   logic                     pol_evict_ready;
   logic [NUM_WAYS-1:0]      pol_evict_target;
   logic                     pol_allocate;
   logic [NUM_WAYS-1:0]      pol_allocate_way;
   logic                     wb_req;
   logic [NUM_WAYS-1:0]      wb_way;
   logic                     wb_done;
   logic                     fill_req;
   logic [ADDRESS_WIDTH-1:0] fill_addr;
   logic [NUM_WAYS-1:0]      fill_way;
   logic                     fill_done;
   logic                     done;
   logic [NUM_WAYS-1:0]      done_way;
   logic                     victim_err;

   // Cache controller / policy / memory side.
   modport master (
      output req_valid, req_addr, req_hit, req_hit_way, way_valid, way_dirty,
      output pol_evict_ready, pol_evict_target, wb_done, fill_done,
      input  req_ready, pol_hit, pol_hit_way, pol_evict_req, pol_allocate, pol_allocate_way,
      input  wb_req, wb_way, fill_req, fill_addr, fill_way, done, done_way, victim_err
   );

   // Sequencer side.
   modport slave (
      input  req_valid, req_addr, req_hit, req_hit_way, way_valid, way_dirty,
      input  pol_evict_ready, pol_evict_target, wb_done, fill_done,
      output req_ready, pol_hit, pol_hit_way, pol_evict_req, pol_allocate, pol_allocate_way,
      output wb_req, wb_way, fill_req, fill_addr, fill_way, done, done_way, victim_err
   );
endinterface

// File: rtl/cache_miss_sequencer_way_prio_enc.sv
// rtl/cache_miss_sequencer_way_prio_enc.sv - lowest-index one-hot priority encoder over a way vector
module way_prio_enc #(
   parameter int NUM_WAYS = 8
) (
   input  logic [NUM_WAYS-1:0] vec,
   output logic [NUM_WAYS-1:0] onehot,
   output logic                any_set
);
   localparam logic [NUM_WAYS-1:0] ONE = NUM_WAYS'(1);

   // Two's complement leaves only the lowest set bit standing.
   assign onehot  = vec & (~vec + ONE);
   assign any_set = |vec;
endmodule

// File: rtl/cache_miss_sequencer.sv
// rtl/cache_miss_sequencer.sv - per-request hit update / victim / writeback / fill / allocate sequencer
module cache_miss_sequencer
   import cache_seq_pkg::*;
#(
   parameter int NUM_WAYS      = 8,
   parameter int ADDRESS_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset_n,
   cache_miss_sequencer_if.slave  bus
);
   localparam logic [NUM_WAYS-1:0] WAY0 = NUM_WAYS'(1);

   seq_state_e               state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [NUM_WAYS-1:0]      hit_way_q, valid_q, dirty_q;
   logic [NUM_WAYS-1:0]      victim_q, victim_d;
   logic [NUM_WAYS-1:0]      inv_onehot, tgt_low, tgt_sel;
   logic                     inv_any, tgt_any, tgt_onehot, accept;

   assign accept     = bus.req_valid && (state_q == IDLE);
   assign tgt_onehot = is_onehot(MAX_WAYS'(bus.pol_evict_target));
   // A malformed policy target falls back to its lowest set way, or way 0 when empty.
   assign tgt_sel    = tgt_onehot ? bus.pol_evict_target : (tgt_any ? tgt_low : WAY0);

   way_prio_enc #(.NUM_WAYS(NUM_WAYS)) u_inv_enc (
      .vec     (~valid_q),
      .onehot  (inv_onehot),
      .any_set (inv_any)
   );

   way_prio_enc #(.NUM_WAYS(NUM_WAYS)) u_tgt_enc (
      .vec     (bus.pol_evict_target),
      .onehot  (tgt_low),
      .any_set (tgt_any)
   );

   // State register plus the set snapshot taken when a lookup is accepted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         hit_way_q <= '0;
         valid_q   <= '0;
         dirty_q   <= '0;
         victim_q  <= '0;
      end else begin
         state_q  <= state_d;
         victim_q <= victim_d;
         if (accept) begin
            addr_q    <= bus.req_addr;
            hit_way_q <= bus.req_hit_way;
            valid_q   <= bus.way_valid;
            dirty_q   <= bus.way_dirty;
         end
      end
   end

   // Next state and all handshake outputs; way buses stay zero unless their strobe is up.
   always_comb begin
      state_d              = state_q;
      victim_d             = victim_q;
      bus.req_ready        = 1'b0;
      bus.pol_hit          = 1'b0;
      bus.pol_hit_way      = '0;
      bus.pol_evict_req    = 1'b0;
      bus.pol_allocate     = 1'b0;
      bus.pol_allocate_way = '0;
      bus.wb_req           = 1'b0;
      bus.wb_way           = '0;
      bus.fill_req         = 1'b0;
      bus.fill_addr        = '0;
      bus.fill_way         = '0;
      bus.done             = 1'b0;
      bus.done_way         = '0;
      bus.victim_err       = 1'b0;
      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) state_d = bus.req_hit ? HIT_UPD : VICTIM;
         end
         HIT_UPD: begin
            bus.pol_hit     = 1'b1;
            bus.pol_hit_way = hit_way_q;
            bus.done        = 1'b1;
            bus.done_way    = hit_way_q;
            state_d         = IDLE;
         end
         VICTIM: begin
            if (inv_any) begin
               // An empty way is free to fill; the policy is not consulted.
               victim_d = inv_onehot;
               state_d  = FILL;
            end else begin
               bus.pol_evict_req = 1'b1;
               if (bus.pol_evict_ready) begin
                  victim_d       = tgt_sel;
                  bus.victim_err = !tgt_onehot;
                  state_d        = (|(dirty_q & tgt_sel)) ? WRITEBACK : FILL;
               end
            end
         end
         WRITEBACK: begin
            bus.wb_req = 1'b1;
            bus.wb_way = victim_q;
            if (bus.wb_done) state_d = FILL;
         end
         FILL: begin
            bus.fill_req  = 1'b1;
            bus.fill_addr = addr_q;
            bus.fill_way  = victim_q;
            if (bus.fill_done) state_d = ALLOC;
         end
         ALLOC: begin
            bus.pol_allocate     = 1'b1;
            bus.pol_allocate_way = victim_q;
            bus.done             = 1'b1;
            bus.done_way         = victim_q;
            state_d              = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_cache_miss_sequencer.sv
// tb/tb_cache_miss_sequencer.sv - scoreboard bench for the cache miss sequencer
module tb_cache_miss_sequencer;
   localparam int NW = 8;
   localparam int AW = 32;

   typedef struct {
      bit            is_hit;
      logic [NW-1:0] way;
      int            lat;
      int            evict_n;
      int            wb_n;
      int            fill_n;
      int            err_n;
      logic [NW-1:0] wb_way;
      logic [AW-1:0] addr;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   cache_miss_sequencer_if #(.NUM_WAYS(NW), .ADDRESS_WIDTH(AW)) bus ();

   cache_miss_sequencer #(.NUM_WAYS(NW), .ADDRESS_WIDTH(AW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   exp_t sb[$];

   int            evict_delay = 1;
   int            wb_delay = 1;
   int            fill_delay = 1;
   logic [NW-1:0] evict_target = '0;
   int            tmo_events = 0;
   int            tmo_seen = 0;
   string         tmo_name = "none";

   function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endfunction

   function automatic exp_t mk(bit h, logic [NW-1:0] w, int lat, int ev, int wb, int fl, int er,
                               logic [NW-1:0] wbw, logic [AW-1:0] a);
      exp_t e;
      e.is_hit = h; e.way = w; e.lat = lat; e.evict_n = ev; e.wb_n = wb;
      e.fill_n = fl; e.err_n = er; e.wb_way = wbw; e.addr = a;
      return e;
   endfunction

   always @(posedge clk) cyc++;

   // Policy / writeback / fill responders: answer in the N-th cycle a request is held.
   int ev_c = 0, wb_c = 0, fl_c = 0;
   always @(posedge clk) begin
      #1;
      if (bus.pol_evict_req) ev_c++; else ev_c = 0;
      if (bus.wb_req) wb_c++; else wb_c = 0;
      if (bus.fill_req) fl_c++; else fl_c = 0;
      bus.pol_evict_ready  = bus.pol_evict_req && (ev_c == evict_delay);
      bus.pol_evict_target = evict_target;
      bus.wb_done          = bus.wb_req && (wb_c == wb_delay);
      bus.fill_done        = bus.fill_req && (fl_c == fill_delay);
   end

   // Monitor: protocol checks every cycle, scoreboard compare on every done.
   int            acc_cyc = 0, ev_n = 0, wb_n = 0, fl_n = 0, er_n = 0;
   int            last_wb_cyc = 0, first_fill_cyc = 0;
   logic [NW-1:0] wb_way_s = '0, fill_way_s = '0;
   logic [AW-1:0] fill_addr_s = '0;
   bit            expect_ready = 0, done_prev = 0;
   exp_t          e;
   always @(negedge clk) begin
      chk({"timeout_", tmo_name}, tmo_events, tmo_seen);
      tmo_seen = tmo_events;
      if (!reset_n) begin
         chk("rst_req_ready", bus.req_ready, 1);
         chk("rst_done", bus.done, 0);
         chk("rst_fill_req", bus.fill_req, 0);
         chk("rst_pol_allocate", bus.pol_allocate, 0);
         chk("rst_pol_hit", bus.pol_hit, 0);
         chk("rst_evict_wb", {bus.pol_evict_req, bus.wb_req, bus.victim_err}, 0);
         expect_ready = 0;
         done_prev = 0;
      end else begin
         chk("excl_pol", bus.pol_hit & bus.pol_allocate, 0);
         chk("excl_req", ($countones({bus.wb_req, bus.fill_req, bus.pol_evict_req}) <= 1), 1);
         chk("done_pulse", bus.done & done_prev, 0);
         if (!bus.pol_hit) chk("pol_hit_way_idle", bus.pol_hit_way, 0);
         if (!bus.pol_allocate) chk("pol_allocate_way_idle", bus.pol_allocate_way, 0);
         if (!bus.wb_req) chk("wb_way_idle", bus.wb_way, 0);
         if (!bus.fill_req) chk("fill_way_idle", bus.fill_way, 0);
         if (!bus.done) chk("done_way_idle", bus.done_way, 0);
         if (expect_ready) chk("ready_after_done", bus.req_ready, 1);
         if (bus.req_valid && bus.req_ready) begin
            acc_cyc = cyc; ev_n = 0; wb_n = 0; fl_n = 0; er_n = 0;
         end
         if (bus.pol_evict_req) ev_n++;
         if (bus.victim_err) er_n++;
         if (bus.wb_req) begin
            wb_n++; wb_way_s = bus.wb_way; last_wb_cyc = cyc;
         end
         if (bus.fill_req) begin
            if (fl_n == 0) begin
               first_fill_cyc = cyc; fill_way_s = bus.fill_way; fill_addr_s = bus.fill_addr;
            end
            fl_n++;
         end
         if (bus.done) begin
            chk("done_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("done_way", bus.done_way, e.way);
               chk("pol_hit", bus.pol_hit, e.is_hit);
               chk("pol_allocate", bus.pol_allocate, !e.is_hit);
               chk("strobe_way", e.is_hit ? bus.pol_hit_way : bus.pol_allocate_way, e.way);
               chk("latency", cyc - acc_cyc, e.lat);
               chk("evict_req_cycles", ev_n, e.evict_n);
               chk("wb_req_cycles", wb_n, e.wb_n);
               chk("fill_req_cycles", fl_n, e.fill_n);
               chk("victim_err_cycles", er_n, e.err_n);
               if (e.fill_n > 0) begin
                  chk("fill_way", fill_way_s, e.way);
                  chk("fill_addr", fill_addr_s, e.addr);
               end
               if (e.wb_n > 0) begin
                  chk("wb_way", wb_way_s, e.wb_way);
                  chk("fill_after_wb", first_fill_cyc, last_wb_cyc + 1);
               end
            end
         end
         expect_ready = bus.done;
         done_prev = bus.done;
      end
   end

   task automatic flag_timeout(string name);
      tmo_name = name;
      tmo_events++;
   endtask

   task automatic drain(string name);
      int n = 0;
      while ((sb.size() != 0 || !bus.req_ready) && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (sb.size() != 0 || !bus.req_ready) flag_timeout(name);
   endtask

   task automatic run(string name, logic [AW-1:0] addr, bit hit, logic [NW-1:0] hway,
                      logic [NW-1:0] valid, logic [NW-1:0] dirty, int ed, logic [NW-1:0] tgt,
                      int wd, int fd, bit push, exp_t ex);
      evict_delay = ed; evict_target = tgt; wb_delay = wd; fill_delay = fd;
      if (push) sb.push_back(ex);
      @(posedge clk); #1;
      bus.req_valid = 1'b1; bus.req_addr = addr; bus.req_hit = hit;
      bus.req_hit_way = hway; bus.way_valid = valid; bus.way_dirty = dirty;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      if (push) drain(name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_hit = 1'b0;
      bus.req_hit_way = '0; bus.way_valid = '0; bus.way_dirty = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      run("hit", 32'h0000_1000, 1, 8'h04, 8'hFF, 8'h00, 1, 8'h00, 1, 1, 1,
          mk(1, 8'h04, 1, 0, 0, 0, 0, 8'h00, 32'h0));
      run("miss_invalid", 32'h0000_2040, 0, 8'h00, 8'hF7, 8'h80, 1, 8'h00, 1, 1, 1,
          mk(0, 8'h08, 3, 0, 0, 1, 0, 8'h00, 32'h0000_2040));
      run("miss_clean", 32'h0000_3080, 0, 8'h00, 8'hFF, 8'h00, 4, 8'h20, 1, 1, 1,
          mk(0, 8'h20, 6, 4, 0, 1, 0, 8'h00, 32'h0000_3080));
      run("miss_dirty", 32'hDEAD_BEC0, 0, 8'h00, 8'hFF, 8'h20, 1, 8'h20, 5, 1, 1,
          mk(0, 8'h20, 8, 1, 5, 1, 0, 8'h20, 32'hDEAD_BEC0));
      run("bad_target_multi", 32'h0000_4000, 0, 8'h00, 8'hFF, 8'h00, 2, 8'h30, 1, 1, 1,
          mk(0, 8'h10, 4, 2, 0, 1, 1, 8'h00, 32'h0000_4000));
      run("bad_target_zero", 32'h0000_5000, 0, 8'h00, 8'hFF, 8'h00, 2, 8'h00, 1, 1, 1,
          mk(0, 8'h01, 4, 2, 0, 1, 1, 8'h00, 32'h0000_5000));
      run("slow_fill_way0", 32'h0000_6000, 0, 8'h00, 8'hFE, 8'h00, 1, 8'h00, 1, 3, 1,
          mk(0, 8'h01, 5, 0, 0, 3, 0, 8'h00, 32'h0000_6000));

      // Reset while the fill is outstanding: the request is abandoned with no done.
      run("reset_mid_fill", 32'h0000_7000, 0, 8'h00, 8'hF7, 8'h00, 1, 8'h00, 1, 1000, 0,
          mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 32'h0));
      n = 0;
      while (!bus.fill_req && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (!bus.fill_req) flag_timeout("wait_fill_req");
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk); #2;
      reset_n = 1'b1;

      run("hit_after_reset", 32'h0000_8000, 1, 8'h80, 8'hFF, 8'h00, 1, 8'h00, 1, 1, 1,
          mk(1, 8'h80, 1, 0, 0, 0, 0, 8'h00, 32'h0));

      repeat (3) @(negedge clk);
      @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
